// File: rtl/sid_bus_master.sv
// 6502-style bus initiator for a SID register interface.
// It generates a free-running phi2 and runs one phi2-aligned register access for each accepted request.
module sid_bus_master #(
  parameter int HALF_PERIOD = 8
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       phi2_out,
  output logic       ceb_out,
  output logic       rwb_out,
  output logic [5:0] addr_out,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  localparam logic [7:0] CNT_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_END
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic       at_last;
  logic       fall_pt;
  logic       rise_pt;
  logic       we_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic       rsp_valid_q;

  // phase generator
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt      <= '0;
      phi2_out <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      phi2_out <= ~phi2_out;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign at_last = (cnt == CNT_LAST);
  assign fall_pt = phi2_out & at_last;
  assign rise_pt = ~phi2_out & at_last;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // An access only begins at a phase boundary, so WAIT blocks until the next fall point.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid) state_nx = S_WAIT;
      S_WAIT:  if (fall_pt) state_nx = S_ADDR;
      S_ADDR:  if (rise_pt) state_nx = S_DATA;
      S_DATA:  if (fall_pt) state_nx = S_END;
      S_END:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // request capture
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // registered bus outputs, driven from the state being entered
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ceb_out     <= 1'b1;
      rwb_out     <= 1'b1;
      addr_out    <= '0;
      bus_out     <= '0;
      bus_oe      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid_q <= (state_nx == S_END);
      case (state_nx)
        S_ADDR: begin
          ceb_out  <= 1'b0;
          rwb_out  <= ~we_q;
          addr_out <= addr_q;
          bus_oe   <= 1'b0;
        end
        S_DATA: begin
          if (we_q) begin
            bus_oe  <= 1'b1;
            bus_out <= wdata_q;
          end
        end
        S_END: begin
          // END is entered only at the fall point, which is the read sample instant.
          if (!we_q) rsp_rdata <= bus_in;
        end
        default: begin
          ceb_out <= 1'b1;
          rwb_out <= 1'b1;
          bus_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state == S_IDLE) & rst_n;
  assign rsp_valid = rsp_valid_q & rst_n;

endmodule

// File: tb/tb_sid_bus_master.sv
// Bench for sid_bus_master with HALF_PERIOD=4. A schedule model computes the expected outputs on every cycle.
// Directed scenarios add literal checks that pin the model.
module tb_sid_bus_master;

  localparam int HP = 4;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       phi2_out;
  logic       ceb_out;
  logic       rwb_out;
  logic [5:0] addr_out;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;

  always #5 clk_i = ~clk_i;

  sid_bus_master #(.HALF_PERIOD(HP)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .phi2_out  (phi2_out),
    .ceb_out   (ceb_out),
    .rwb_out   (rwb_out),
    .addr_out  (addr_out),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state. c counts the cycles since reset release, with cycle 0 showing the reset values.
  int         c = 0;
  bit         started = 1'b0;
  bit         busy = 1'b0;
  bit         t_we = 1'b0;
  logic [5:0] t_addr = '0;
  logic [7:0] t_wdata = '0;
  int         t_a = 0;
  int         t_d = 0;
  int         t_e = 0;
  logic [5:0] addr_e = '0;
  logic [7:0] bus_e = '0;
  logic [7:0] rdata_e = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  // First fall point (phi2 high, last count) strictly after the accept cycle.
  function automatic int first_fall_after(int k);
    int per;
    int f;
    per = 2 * HP;
    f = (k / per) * per + per - 1;
    if (f <= k) f += per;
    return f;
  endfunction

  always @(posedge clk_i) begin
    if (!rst_n) begin
      started <= 1'b1;
      c       <= 0;
      busy    <= 1'b0;
      addr_e  <= '0;
      bus_e   <= '0;
      rdata_e <= '0;
    end else if (started) begin
      if (!busy && req_valid) begin
        busy    <= 1'b1;
        t_we    <= req_we;
        t_addr  <= req_addr;
        t_wdata <= req_wdata;
        t_a     <= first_fall_after(c) + 1;
        t_d     <= first_fall_after(c) + 1 + HP;
        t_e     <= first_fall_after(c) + 1 + 2 * HP;
      end
      if (busy && c == t_e) busy <= 1'b0;
      if (busy && c == t_a - 1) addr_e <= t_addr;
      if (busy && t_we && c == t_d - 1) bus_e <= t_wdata;
      if (busy && !t_we && c == t_e - 1) rdata_e <= bus_in;
      c <= c + 1;
    end
  end

  always @(negedge clk_i) begin : cmp
    logic acc;
    if (started) begin
      acc = busy && c >= t_a && c <= t_e;
      check("phi2_out", phi2_out, ((c / HP) % 2));
      check("ceb_out", ceb_out, !acc);
      check("rwb_out", rwb_out, acc ? !t_we : 1'b1);
      check("bus_oe", bus_oe, busy && t_we && c >= t_d && c <= t_e);
      check("rsp_valid", rsp_valid, rst_n && busy && c == t_e);
      check("req_ready", req_ready, rst_n && !busy);
      check("addr_out", addr_out, addr_e);
      check("bus_out", bus_out, bus_e);
      check("rsp_rdata", rsp_rdata, rdata_e);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic until_cyc(int k);
    int guard;
    guard = 0;
    while (c != k && guard < 200) begin
      step();
      guard++;
    end
    if (c != k) begin
      n_cmp++;
      n_bad++;
      $display("FAIL until_cyc: reached cycle %0d, wanted %0d", c, k);
    end
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", c);
    $fatal(1);
  end

  initial begin
    int pulses;
    int rise1;
    int rise2;
    int highs;
    bit ceb_low;
    logic p [0:39];

    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    bus_in    = '0;

    // reset hold with a pending request
    repeat (5) step();
    check("rst req_ready", req_ready, 0);
    check("rst ceb_out", ceb_out, 1);
    check("rst rwb_out", rwb_out, 1);
    check("rst bus_oe", bus_oe, 0);
    check("rst phi2_out", phi2_out, 0);
    check("rst rsp_valid", rsp_valid, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // write 0x5A to 0x18
    until_cyc(1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h18; req_wdata = 8'h5A;
    check("wr ready c1", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("wr ready c2", req_ready, 0);
    until_cyc(7);
    check("wr ceb c7", ceb_out, 1);
    until_cyc(8);
    check("wr ceb c8", ceb_out, 0);
    check("wr rwb c8", rwb_out, 0);
    check("wr addr c8", addr_out, 8'h18);
    check("wr oe c8", bus_oe, 0);
    until_cyc(12);
    check("wr oe c12", bus_oe, 1);
    check("wr bus c12", bus_out, 8'h5A);
    until_cyc(15);
    check("wr rsp c15", rsp_valid, 0);
    until_cyc(16);
    check("wr rsp c16", rsp_valid, 1);
    check("wr ceb c16", ceb_out, 0);
    check("wr oe c16", bus_oe, 1);
    until_cyc(17);
    check("wr ready c17", req_ready, 1);
    check("wr ceb c17", ceb_out, 1);
    check("wr rwb c17", rwb_out, 1);
    check("wr oe c17", bus_oe, 0);
    check("wr rsp c17", rsp_valid, 0);
    check("wr addr hold c17", addr_out, 8'h18);

    // read 0x1B, target drives 0xC3 only in the sample cycle
    do_reset(2);
    until_cyc(1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h1B;
    step();
    req_valid = 1'b0;
    until_cyc(8);
    check("rd ceb c8", ceb_out, 0);
    check("rd rwb c8", rwb_out, 1);
    check("rd addr c8", addr_out, 8'h1B);
    until_cyc(12);
    check("rd oe c12", bus_oe, 0);
    until_cyc(15);
    bus_in = 8'hC3;
    check("rd rdata c15", rsp_rdata, 0);
    step();
    bus_in = 8'h00;
    check("rd rdata c16", rsp_rdata, 8'hC3);
    check("rd rsp c16", rsp_valid, 1);
    step();
    check("rd rdata c17", rsp_rdata, 8'hC3);
    check("rd rsp c17", rsp_valid, 0);

    // back-to-back write then read, request held continuously
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h05; req_wdata = 8'hA5;
    step();
    req_we = 1'b0; req_addr = 6'h0A;
    until_cyc(24);
    check("b2b wr ceb c24", ceb_out, 0);
    check("b2b wr rwb c24", rwb_out, 0);
    check("b2b wr addr c24", addr_out, 8'h05);
    until_cyc(31);
    bus_in = 8'h77;
    step();
    bus_in = 8'h00;
    check("b2b wr rsp c32", rsp_valid, 1);
    check("b2b wr rdata c32", rsp_rdata, 8'hC3);
    until_cyc(33);
    check("b2b ready c33", req_ready, 1);
    check("b2b rdata c33", rsp_rdata, 8'hC3);
    step();
    req_valid = 1'b0;
    until_cyc(40);
    check("b2b rd ceb c40", ceb_out, 0);
    check("b2b rd rwb c40", rwb_out, 1);
    check("b2b rd addr c40", addr_out, 8'h0A);
    until_cyc(47);
    bus_in = 8'h3C;
    step();
    bus_in = 8'h00;
    check("b2b rd rsp c48", rsp_valid, 1);
    check("b2b rd rdata c48", rsp_rdata, 8'h3C);

    // reset in the middle of a write
    do_reset(2);
    until_cyc(1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h2A; req_wdata = 8'h99;
    step();
    req_valid = 1'b0;
    until_cyc(13);
    check("mid oe c13", bus_oe, 1);
    rst_n = 1'b0;
    step();
    check("mid ceb c14", ceb_out, 1);
    check("mid oe c14", bus_oe, 0);
    check("mid phi2 c14", phi2_out, 0);
    check("mid rwb c14", rwb_out, 1);
    check("mid ready c14", req_ready, 0);
    check("mid rsp c14", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      step();
      if (rsp_valid) pulses++;
    end
    check("mid dropped rsp", pulses, 0);

    // request accepted at the fall point waits for the next one
    do_reset(1);
    until_cyc(7);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h01;
    step();
    req_valid = 1'b0;
    check("fp ready c8", req_ready, 0);
    check("fp ceb c8", ceb_out, 1);
    until_cyc(15);
    check("fp ceb c15", ceb_out, 1);
    step();
    check("fp ceb c16", ceb_out, 0);
    until_cyc(24);
    check("fp rsp c24", rsp_valid, 1);

    // free-running phi2 with no requests
    do_reset(1);
    ceb_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p[i] = phi2_out;
      if (!ceb_out) ceb_low = 1'b1;
      step();
    end
    rise1 = -1;
    rise2 = -1;
    highs = 0;
    for (int i = 1; i < 40; i++) begin
      if (!p[i-1] && p[i]) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
    end
    for (int i = 0; i < 32; i++) if (p[i]) highs++;
    check("phi2 first rise", rise1, 4);
    check("phi2 period", rise2 - rise1, 8);
    check("phi2 duty", highs, 16);
    check("phi2 idle ceb", ceb_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
